// File: rtl/sdvm_digit_ctrl.sv
// Digit sequencer for the signed-digit vector multiplier. It latches the operand rails on start,
// then forwards one signed digit per cycle as a registered select and tags each partial product.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; no digits accepted, operand rails held
// ST_RUN  | operation in progress; one digit accepted per valid cycle
module sdvm_digit_ctrl #(
   parameter int NUM_BITS   = 2,
   parameter int NUM_DIGITS = 8,
   parameter int CNT_W      = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic                i_abort,
   input  logic [NUM_BITS-1:0] i_vec_plus_in,
   input  logic [NUM_BITS-1:0] i_vec_minus_in,
   input  logic [1:0]          i_digit_in,
   input  logic                i_digit_valid,
   output logic                o_digit_ready,
   output logic [1:0]          o_sel_out,
   output logic [NUM_BITS-1:0] o_vec_plus_out,
   output logic [NUM_BITS-1:0] o_vec_minus_out,
   output logic                o_pp_valid,
   output logic [CNT_W-1:0]    o_pp_index,
   output logic                o_pp_last,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err_digit
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [1:0]       DIG_ZERO    = 2'b00;
   localparam logic [1:0]       DIG_ILLEGAL = 2'b11;
   localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(NUM_DIGITS - 1);

   logic [0:0]          r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [1:0]          r_sel;
   logic [NUM_BITS-1:0] r_vec_plus;
   logic [NUM_BITS-1:0] r_vec_minus;
   logic                r_pp_valid;
   logic [CNT_W-1:0]    r_pp_index;
   logic                r_pp_last;
   logic                r_done;
   logic                r_err;

   logic w_run;
   logic w_start_ok;
   logic w_accept;
   logic w_illegal;
   logic w_last;

   assign w_run      = (r_state == ST_RUN);
   assign w_start_ok = (r_state == ST_IDLE) && i_start && !i_abort;
   // Abort masks ready so a digit offered alongside it is never consumed.
   assign w_accept   = w_run && !i_abort && i_digit_valid;
   assign w_illegal  = (i_digit_in == DIG_ILLEGAL);
   assign w_last     = (r_cnt == LAST_IDX);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_sel       <= DIG_ZERO;
         r_vec_plus  <= '0;
         r_vec_minus <= '0;
         r_pp_valid  <= 1'b0;
         r_pp_index  <= '0;
         r_pp_last   <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_sel      <= DIG_ZERO;
         r_pp_valid <= 1'b0;
         r_pp_last  <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_start_ok) begin
                  r_vec_plus  <= i_vec_plus_in;
                  r_vec_minus <= i_vec_minus_in;
                  r_cnt       <= '0;
                  r_err       <= 1'b0;
                  r_state     <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (i_abort) begin
                  r_state <= ST_IDLE;
               end else if (w_accept) begin
                  r_sel      <= w_illegal ? DIG_ZERO : i_digit_in;
                  r_err      <= r_err | w_illegal;
                  r_pp_valid <= 1'b1;
                  r_pp_index <= r_cnt;
                  r_cnt      <= r_cnt + 1'b1;
                  if (w_last) begin
                     r_pp_last <= 1'b1;
                     r_done    <= 1'b1;
                     r_state   <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_digit_ready   = w_run && !i_abort;
   assign o_busy          = w_run;
   assign o_sel_out       = r_sel;
   assign o_vec_plus_out  = r_vec_plus;
   assign o_vec_minus_out = r_vec_minus;
   assign o_pp_valid      = r_pp_valid;
   assign o_pp_index      = r_pp_index;
   assign o_pp_last       = r_pp_last;
   assign o_done          = r_done;
   assign o_err_digit     = r_err;

endmodule

// File: tb/tb_sdvm_digit_ctrl.sv
// Bench for sdvm_digit_ctrl: directed scenarios plus random traffic, each cycle compared
// against a behavioural model of an operation (digits-accepted count, operand, error flag).
module tb_sdvm_digit_ctrl;

   localparam int NB = 2;
   localparam int ND = 4;
   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [NB-1:0] vec_plus_in;
   logic [NB-1:0] vec_minus_in;
   logic [1:0]    digit_in;
   logic          digit_valid;
   logic          digit_ready;
   logic [1:0]    sel_out;
   logic [NB-1:0] vec_plus_out;
   logic [NB-1:0] vec_minus_out;
   logic          pp_valid;
   logic [CW-1:0] pp_index;
   logic          pp_last;
   logic          busy;
   logic          done;
   logic          err_digit;

   sdvm_digit_ctrl #(.NUM_BITS(NB), .NUM_DIGITS(ND), .CNT_W(CW)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_start        (start),
      .i_abort        (abort),
      .i_vec_plus_in  (vec_plus_in),
      .i_vec_minus_in (vec_minus_in),
      .i_digit_in     (digit_in),
      .i_digit_valid  (digit_valid),
      .o_digit_ready  (digit_ready),
      .o_sel_out      (sel_out),
      .o_vec_plus_out (vec_plus_out),
      .o_vec_minus_out(vec_minus_out),
      .o_pp_valid     (pp_valid),
      .o_pp_index     (pp_index),
      .o_pp_last      (pp_last),
      .o_busy         (busy),
      .o_done         (done),
      .o_err_digit    (err_digit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst_n;
      logic       start;
      logic       abort;
      logic [1:0] pv;
      logic [1:0] mv;
      logic       dv;
      logic [1:0] d;
   } stim_t;

   int checks   = 0;
   int failures = 0;

   // Model of one operation: is one in flight, how many digits it has consumed so far.
   bit         m_active;
   int         m_taken;
   logic [1:0] m_plus, m_minus;
   bit         m_err;
   int         m_idx;
   logic [1:0] e_sel;
   bit         e_ppv, e_last, e_done, e_ready;
   logic       got_ready;

   function automatic stim_t mk(logic rn, logic st, logic ab, logic [1:0] pv, logic [1:0] mv,
                                logic dv, logic [1:0] d);
      stim_t s;
      s.rst_n = rn; s.start = st; s.abort = ab; s.pv = pv; s.mv = mv; s.dv = dv; s.d = d;
      return s;
   endfunction

   function automatic stim_t dig(logic [1:0] d);
      return mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, d);
   endfunction

   function automatic stim_t idle_c();
      return mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00);
   endfunction

   function automatic logic [1:0] rand_legal();
      logic [1:0] codes [3];
      codes[0] = 2'b00; codes[1] = 2'b01; codes[2] = 2'b10;
      return codes[$urandom_range(0, 2)];
   endfunction

   function automatic logic [14:0] obs();
      return {sel_out, pp_valid, pp_index, pp_last, busy, done, err_digit, vec_plus_out, vec_minus_out};
   endfunction

   function automatic logic [14:0] expv();
      return {e_sel, e_ppv, 4'(m_idx), e_last, m_active, e_done, m_err, m_plus, m_minus};
   endfunction

   // Apply one cycle of inputs, sample the combinational ready, and advance the model.
   task automatic drive(input stim_t s);
      rst_n = s.rst_n; start = s.start; abort = s.abort;
      vec_plus_in = s.pv; vec_minus_in = s.mv; digit_valid = s.dv; digit_in = s.d;
      #1;
      got_ready = digit_ready;
      e_ready = m_active && !s.abort;
      e_sel = 2'b00; e_ppv = 0; e_last = 0; e_done = 0;
      if (!s.rst_n) begin
         m_active = 0; m_taken = 0; m_plus = 0; m_minus = 0; m_err = 0; m_idx = 0;
      end else if (!m_active) begin
         if (s.start && !s.abort) begin
            m_active = 1; m_taken = 0; m_err = 0; m_plus = s.pv; m_minus = s.mv;
         end
      end else if (s.abort) begin
         m_active = 0;
      end else if (s.dv) begin
         e_sel = (s.d == 2'b11) ? 2'b00 : s.d;
         m_err = m_err || (s.d == 2'b11);
         e_ppv = 1;
         m_idx = m_taken;
         m_taken++;
         if (m_taken == ND) begin
            e_last = 1; e_done = 1; m_active = 0;
         end
      end
   endtask

   task automatic test_reset();
      stim_t q[$];
      q.push_back(mk(1'b0, 1'b1, 1'b0, 2'b11, 2'b11, 1'b1, 2'b10));
      q.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00));
      q.push_back(idle_c());
      q.push_back(idle_c());
      foreach (q[i]) begin
         drive(q[i]);
         @(posedge clk); #1;
         checks++;
         if ({got_ready, obs()} !== {e_ready, expv()} || obs() !== 15'd0) begin
            failures++;
            $display("FAIL reset cyc %0d: got %h want %h", i, {got_ready, obs()}, {e_ready, expv()});
         end
      end
   endtask

   task automatic test_basic();
      stim_t q[$];
      q.push_back(mk(1'b1, 1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 2'b00));
      q.push_back(dig(2'b10));
      q.push_back(dig(2'b01));
      q.push_back(dig(2'b00));
      q.push_back(dig(2'b10));
      q.push_back(dig(2'b01));
      q.push_back(idle_c());
      foreach (q[i]) begin
         drive(q[i]);
         @(posedge clk); #1;
         checks++;
         if ({got_ready, obs()} !== {e_ready, expv()}) begin
            failures++;
            $display("FAIL basic cyc %0d: got %h want %h", i, {got_ready, obs()}, {e_ready, expv()});
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t q[$];
      for (int op = 0; op < 3; op++) begin
         q.push_back(mk(1'b1, 1'b1, 1'b0, 2'($urandom), 2'($urandom), 1'b0, 2'b00));
         for (int k = 0; k < ND; k++) q.push_back(dig(rand_legal()));
      end
      q.push_back(idle_c());
      foreach (q[i]) begin
         drive(q[i]);
         @(posedge clk); #1;
         checks++;
         if ({got_ready, obs()} !== {e_ready, expv()}) begin
            failures++;
            $display("FAIL back_to_back cyc %0d: got %h want %h", i, {got_ready, obs()}, {e_ready, expv()});
         end
      end
   endtask

   task automatic test_gaps();
      stim_t q[$];
      q.push_back(mk(1'b1, 1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 2'b00));
      q.push_back(dig(rand_legal()));
      q.push_back(mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10));
      q.push_back(mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01));
      q.push_back(dig(rand_legal()));
      q.push_back(dig(rand_legal()));
      q.push_back(idle_c());
      q.push_back(dig(rand_legal()));
      q.push_back(idle_c());
      foreach (q[i]) begin
         drive(q[i]);
         @(posedge clk); #1;
         checks++;
         if ({got_ready, obs()} !== {e_ready, expv()}) begin
            failures++;
            $display("FAIL gaps cyc %0d: got %h want %h", i, {got_ready, obs()}, {e_ready, expv()});
         end
      end
   endtask

   task automatic test_illegal();
      stim_t q[$];
      q.push_back(mk(1'b1, 1'b1, 1'b0, 2'b11, 2'b01, 1'b0, 2'b00));
      q.push_back(dig(rand_legal()));
      q.push_back(dig(2'b11));
      q.push_back(idle_c());
      q.push_back(dig(rand_legal()));
      q.push_back(dig(rand_legal()));
      q.push_back(idle_c());
      q.push_back(mk(1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 2'b00));
      q.push_back(dig(2'b10));
      foreach (q[i]) begin
         drive(q[i]);
         @(posedge clk); #1;
         checks++;
         if ({got_ready, obs()} !== {e_ready, expv()}) begin
            failures++;
            $display("FAIL illegal cyc %0d: got %h want %h", i, {got_ready, obs()}, {e_ready, expv()});
         end
      end
      // Finish the pending operation so later tests start from idle.
      for (int k = 0; k < ND; k++) begin
         drive(dig(rand_legal()));
         @(posedge clk); #1;
         checks++;
         if ({got_ready, obs()} !== {e_ready, expv()}) begin
            failures++;
            $display("FAIL illegal_tail cyc %0d: got %h want %h", k, {got_ready, obs()}, {e_ready, expv()});
         end
      end
   endtask

   task automatic test_abort();
      stim_t q[$];
      q.push_back(mk(1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 2'b00));
      q.push_back(dig(2'b01));
      q.push_back(dig(2'b10));
      q.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 2'b10));
      q.push_back(dig(2'b01));
      q.push_back(mk(1'b1, 1'b1, 1'b0, 2'b01, 2'b11, 1'b0, 2'b00));
      for (int k = 0; k < ND; k++) q.push_back(dig(rand_legal()));
      q.push_back(idle_c());
      foreach (q[i]) begin
         drive(q[i]);
         @(posedge clk); #1;
         checks++;
         if ({got_ready, obs()} !== {e_ready, expv()}) begin
            failures++;
            $display("FAIL abort cyc %0d: got %h want %h", i, {got_ready, obs()}, {e_ready, expv()});
         end
      end
   endtask

   task automatic test_start_conflicts();
      stim_t q[$];
      q.push_back(mk(1'b1, 1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 2'b00));
      q.push_back(mk(1'b1, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 2'b01));
      q.push_back(mk(1'b1, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 2'b00));
      for (int k = 0; k < ND - 1; k++) q.push_back(dig(rand_legal()));
      q.push_back(mk(1'b1, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 2'b00));
      q.push_back(idle_c());
      foreach (q[i]) begin
         drive(q[i]);
         @(posedge clk); #1;
         checks++;
         if ({got_ready, obs()} !== {e_ready, expv()}) begin
            failures++;
            $display("FAIL start_conflict cyc %0d: got %h want %h", i, {got_ready, obs()}, {e_ready, expv()});
         end
      end
   endtask

   task automatic test_reset_mid();
      stim_t q[$];
      q.push_back(mk(1'b1, 1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 2'b00));
      for (int k = 0; k < 3; k++) q.push_back(dig(2'b11 - 2'(k)));
      q.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10));
      q.push_back(mk(1'b0, 1'b1, 1'b0, 2'b11, 2'b11, 1'b1, 2'b01));
      q.push_back(idle_c());
      q.push_back(mk(1'b1, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 2'b00));
      for (int k = 0; k < ND; k++) q.push_back(dig(rand_legal()));
      q.push_back(idle_c());
      foreach (q[i]) begin
         drive(q[i]);
         @(posedge clk); #1;
         checks++;
         if ({got_ready, obs()} !== {e_ready, expv()}) begin
            failures++;
            $display("FAIL reset_mid cyc %0d: got %h want %h", i, {got_ready, obs()}, {e_ready, expv()});
         end
      end
   endtask

   task automatic test_random();
      stim_t s;
      for (int i = 0; i < 400; i++) begin
         s.rst_n = ($urandom_range(0, 99) != 0);
         s.start = ($urandom_range(0, 9) < 3);
         s.abort = ($urandom_range(0, 19) == 0);
         s.pv    = 2'($urandom);
         s.mv    = 2'($urandom);
         s.dv    = ($urandom_range(0, 9) < 7);
         s.d     = ($urandom_range(0, 9) == 0) ? 2'b11 : rand_legal();
         drive(s);
         @(posedge clk); #1;
         checks++;
         if ({got_ready, obs()} !== {e_ready, expv()}) begin
            failures++;
            $display("FAIL random cyc %0d: got %h want %h", i, {got_ready, obs()}, {e_ready, expv()});
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; vec_plus_in = '0; vec_minus_in = '0;
      digit_in = 2'b00; digit_valid = 1'b0;
      m_active = 0; m_taken = 0; m_plus = 0; m_minus = 0; m_err = 0; m_idx = 0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_gaps();
      test_illegal();
      test_abort();
      test_start_conflicts();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sdvm_digit_ctrl.md
# sdvm_digit_ctrl

Sequencer for the signed-digit vector multiplier (SDVM) in the online divider datapath. It latches a redundant operand vector (plus/minus rails) on `start`, then accepts a serial stream of signed digits over a valid/ready handshake. For each accepted digit it drives the registered operand and digit select to the SDVM and tags the resulting partial product for the downstream accumulator. It counts digits, signals completion, supports abort and flags illegal digit codes.

## Interface
- `NUM_BITS`, default 2: width of each operand rail.
- `NUM_DIGITS`, default 8: digits per operation; legal range 1 to 2^`CNT_W`.
- `CNT_W`, default 4: width of the digit counter and `pp_index`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `start` in 1: begin an operation; honoured only in IDLE.
- `abort` in 1: cancel the current operation.
- `vec_plus_in` in `NUM_BITS`: operand plus rail, latched on an accepted `start`.
- `vec_minus_in` in `NUM_BITS`: operand minus rail, latched on an accepted `start`.
- `digit_in` in 2: signed digit. 10 = +1, 01 = -1, 00 = 0, 11 = illegal.
- `digit_valid` in 1: `digit_in` is valid.
- `digit_ready` out 1: controller accepts a digit this cycle.
- `sel_out` out 2: registered digit select to the SDVM.
- `vec_plus_out` out `NUM_BITS`: latched operand plus rail to the SDVM.
- `vec_minus_out` out `NUM_BITS`: latched operand minus rail to the SDVM.
- `pp_valid` out 1: the SDVM output this cycle is a valid partial product.
- `pp_index` out `CNT_W`: digit position of the current partial product, starting at 0.
- `pp_last` out 1: the current partial product is the final one.
- `busy` out 1: an operation is in progress.
- `done` out 1: one-cycle completion pulse.
- `err_digit` out 1: sticky flag; an illegal digit was seen in this operation.

## Operation
- **FSM states:** IDLE and RUN.
- **Reset:** all outputs, registers and the counter reset to 0, and the state goes to IDLE.
- **IDLE:**
  - `digit_ready` = 0 and `busy` = 0.
  - When `start` = 1 and `abort` = 0, the block latches both operand rails, clears `cnt` and `err_digit`, and moves to RUN.
- **RUN:**
  - `digit_ready` = 1 and `busy` = 1.
  - A digit is accepted on a cycle with `digit_valid` and `digit_ready`, subject to the abort rule below.
- **On an accepted digit:**
  - `sel_out` takes the digit on the next edge; code 11 is loaded as 00 and sets `err_digit`.
  - `pp_valid` = 1 and `pp_index` = `cnt` on the next edge, then `cnt` increments.
  - If `cnt` = `NUM_DIGITS`-1, `pp_last` and `done` are also set on the next edge, and the state returns to IDLE.
- **No digit accepted in a cycle:** `sel_out` = 00 and `pp_valid` = 0 on the next edge, so the SDVM outputs zero.
- **Abort:** `abort` in RUN returns the state to IDLE on the next edge. `sel_out` = 00, `pp_valid` = 0 and `done` stays 0. A digit presented in the same cycle is not accepted, and `digit_ready` is 0 in that cycle.
- **Start while busy:** `start` in RUN is ignored, and the operand registers hold.
- **Start with abort in IDLE:** abort wins, and the state stays IDLE.
- **Operand rails:** `vec_plus_out` and `vec_minus_out` hold their latched value until the next accepted `start`. They are not cleared on `done` or `abort`.

## Timing
- **Start:**
  - `start` is sampled at edge t.
  - From t+1: `busy` = 1, `digit_ready` = 1, and the operand rails are valid.
- **Digit latency:** a digit accepted at edge k produces `sel_out` and `pp_valid` in cycle k+1 (one cycle). The SDVM output is combinational in that cycle.
- **Throughput:** one digit per cycle. Back-to-back digits give contiguous `pp_valid`.
- **Last digit:** the last digit is accepted at edge k. In cycle k+1, `pp_valid` = `pp_last` = `done` = 1, `busy` = 0 and `digit_ready` = 0. A new `start` can be sampled at the end of cycle k+1.
- **`NUM_DIGITS` = 1:** the first accepted digit is the last one.
- **`err_digit`:** updates in the same cycle k+1 as its digit and holds until the next accepted `start` or reset.
- **Reset mid-operation:** at the reset edge the block goes to IDLE, and all outputs are 0 from the next cycle. No `done` is produced.

## Test plan
All cases use `NUM_BITS` = 2 and `NUM_DIGITS` = 4.

1. **Basic run:**
   - Stimulus: `start` with plus = 10 and minus = 01, then digits 10, 01, 00, 10 back-to-back.
   - Required response: `sel_out` = 10, 01, 00, 10 on consecutive cycles; `pp_index` = 0..3; `pp_last` and `done` only on the 4th; `busy` = 0 afterwards.
2. **Gaps in the stream:**
   - Stimulus: `digit_valid` low for 2 cycles between digits 1 and 2.
   - Required response: `pp_valid` and `sel_out` = 00 in the gap cycles; `pp_index` continues at 1 with no skips; `done` after the 4th accepted digit.
3. **Illegal digit:**
   - Stimulus: the second digit is 11.
   - Required response: `sel_out` = 00 with `pp_valid` = 1 and `pp_index` = 1; `err_digit` = 1 from that cycle through `done`; `err_digit` clears on the next `start`.
4. **Abort:**
   - Stimulus: `abort` after 2 digits, together with a valid digit.
   - Required response: the digit is not accepted, no `done`, IDLE next cycle. A new `start` with 4 digits gives `pp_index` 0..3.
5. **Start conflicts:**
   - Stimulus: `start` with new operand 11/00 in RUN; `start` and `abort` together in IDLE.
   - Required response: operand rails unchanged and `busy` unaffected; the block stays IDLE.
6. **Reset mid-operation:**
   - Stimulus: `rst_n` low after 3 digits.
   - Required response: all outputs 0 from the next cycle and no `done`. After release, a fresh run completes normally.
